// File: rtl/axi_fifo_pkg.sv
// Shared defaults, count-width helper and parameter sanity check for the single-clock AXI-stream FIFO.
// No timing of its own; no backpressure.
package axi_fifo_pkg;

  localparam int FIFO_WIDTH_DEF = 57;
  localparam int FIFO_DEPTH_DEF = 8;

  // Occupancy must reach DEPTH inclusive, hence the extra bit.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit fifo_cfg_ok(input int depth, input int thresh);
    return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (thresh >= 1) && (thresh <= depth);
  endfunction

endpackage

// File: rtl/axi_fifo_sync_mem.sv
// WIDTH x DEPTH flop storage: one synchronous write port, one asynchronous read port.
// Write lands on the clock edge and the read port reflects it the next cycle; no backpressure.
module axi_fifo_sync_mem #(
  parameter int WIDTH = 57,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/axi_fifo_sync.sv
// Single-clock FWFT AXI-stream FIFO; push-to-valid 1 cycle, registered wr_ready_o, flush wins over push/pop.
// Optional sticky overflow flag under AXI_FIFO_OVF_EN; otherwise ovf_o is tied low.
module axi_fifo_sync
  import axi_fifo_pkg::*;
#(
  parameter int WIDTH        = FIFO_WIDTH_DEF,
  parameter int DEPTH        = FIFO_DEPTH_DEF,
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  input  logic                        wr_valid_i,
  input  logic [WIDTH-1:0]            wr_wdata_i,
  output logic                        wr_ready_o,
  output logic                        rd_valid_o,
  output logic [WIDTH-1:0]            rd_rdata_o,
  input  logic                        rd_ready_i,
  output logic [cnt_width(DEPTH)-1:0] count_o,
  output logic                        almost_full_o,
  output logic                        ovf_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_THRESH);

  if (!fifo_cfg_ok(DEPTH, AFULL_THRESH)) begin : g_cfg_err
    $error("axi_fifo_sync: DEPTH must be a power of two >= 2 and AFULL_THRESH in 1..DEPTH");
  end

  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_nxt;
  logic          wr_ready_q;
  logic          push;
  logic          pop;

  assign rd_valid_o    = (cnt_q != '0);
  assign wr_ready_o    = wr_ready_q;
  assign count_o       = cnt_q;
  assign almost_full_o = (cnt_q >= AFULL_C);

  assign push = wr_valid_i && wr_ready_q;
  assign pop  = rd_valid_o && rd_ready_i;

  always_comb begin
    cnt_nxt = cnt_q;
    if (flush_i) begin
      cnt_nxt = '0;
    end else if (push && !pop) begin
      cnt_nxt = cnt_q + 1'b1;
    end else if (pop && !push) begin
      cnt_nxt = cnt_q - 1'b1;
    end
  end

  // Ready comes from next_count so a pop on a full cycle only frees the slot one cycle later.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      wr_ready_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_nxt;
      wr_ready_q <= (cnt_nxt != DEPTH_C);
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  axi_fifo_sync_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (push && !flush_i),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_wdata_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_rdata_o)
  );

`ifdef AXI_FIFO_OVF_EN
  logic ovf_q;
  logic ovf_evt;

  assign ovf_evt = wr_valid_i && !wr_ready_q && !flush_i;
  assign ovf_o   = ovf_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
    end else if (flush_i) begin
      ovf_q <= 1'b0;
    end else if (ovf_evt) begin
      ovf_q <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!rst_i && ovf_evt && !ovf_q) begin
      $display("axi_fifo_sync: write overflow at time %0t", $time);
    end
  end
`endif
`else
  assign ovf_o = 1'b0;
`endif

endmodule

// File: tb/tb_axi_fifo_sync.sv
// Directed bench for axi_fifo_sync (WIDTH=8, DEPTH=4, AFULL_THRESH=3): vector table plus stream/reset sequences.
// Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
module tb_axi_fifo_sync;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       flush_i = 1'b0;
  logic       wr_valid_i = 1'b0;
  logic [7:0] wr_wdata_i = 8'h00;
  logic       wr_ready_o;
  logic       rd_valid_o;
  logic [7:0] rd_rdata_o;
  logic       rd_ready_i = 1'b0;
  logic [2:0] count_o;
  logic       almost_full_o;
  logic       ovf_o;

  int checks = 0;
  int failures = 0;

`ifdef AXI_FIFO_OVF_EN
  localparam logic OV = 1'b1;
`else
  localparam logic OV = 1'b0;
`endif

  always #5 clk_i = ~clk_i;

  axi_fifo_sync #(
    .WIDTH        (8),
    .DEPTH        (4),
    .AFULL_THRESH (3)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .flush_i       (flush_i),
    .wr_valid_i    (wr_valid_i),
    .wr_wdata_i    (wr_wdata_i),
    .wr_ready_o    (wr_ready_o),
    .rd_valid_o    (rd_valid_o),
    .rd_rdata_o    (rd_rdata_o),
    .rd_ready_i    (rd_ready_i),
    .count_o       (count_o),
    .almost_full_o (almost_full_o),
    .ovf_o         (ovf_o)
  );

  typedef struct {
    logic       flush;
    logic       wv;
    logic [7:0] wd;
    logic       rr;
    logic       e_wrdy;
    logic       e_rv;
    logic [7:0] e_rd;
    logic [2:0] e_cnt;
    logic       e_af;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input logic fl, input logic wv, input logic [7:0] wd, input logic rr,
                              input logic e_wrdy, input logic e_rv, input logic [7:0] e_rd,
                              input logic [2:0] e_cnt, input logic e_af, input logic e_ovf);
    vec_t v;
    v.flush = fl; v.wv = wv; v.wd = wd; v.rr = rr;
    v.e_wrdy = e_wrdy; v.e_rv = e_rv; v.e_rd = e_rd;
    v.e_cnt = e_cnt; v.e_af = e_af; v.e_ovf = e_ovf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic fl, input logic wv, input logic [7:0] wd, input logic rr);
    flush_i = fl; wr_valid_i = wv; wr_wdata_i = wd; rd_ready_i = rr;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // flush wv  wd    rr   wrdy rv  rdata  cnt  af   ovf
    vecs[0]  = mk(0, 0, 8'h00, 0,  1, 0, 8'h00, 3'd0, 0, 0);   // ready rises, nothing taken
    vecs[1]  = mk(0, 1, 8'hA1, 0,  1, 1, 8'hA1, 3'd1, 0, 0);
    vecs[2]  = mk(0, 0, 8'h00, 1,  1, 0, 8'h00, 3'd0, 0, 0);
    vecs[3]  = mk(0, 1, 8'h01, 0,  1, 1, 8'h01, 3'd1, 0, 0);
    vecs[4]  = mk(0, 1, 8'h02, 0,  1, 1, 8'h01, 3'd2, 0, 0);
    vecs[5]  = mk(0, 1, 8'h03, 0,  1, 1, 8'h01, 3'd3, 1, 0);
    vecs[6]  = mk(0, 1, 8'h04, 0,  0, 1, 8'h01, 3'd4, 1, 0);
    vecs[7]  = mk(0, 1, 8'h05, 0,  0, 1, 8'h01, 3'd4, 1, OV);  // rejected 5th write
    vecs[8]  = mk(0, 1, 8'h55, 1,  1, 1, 8'h02, 3'd3, 1, OV);  // pop while full, push refused
    vecs[9]  = mk(0, 0, 8'h00, 0,  1, 1, 8'h02, 3'd3, 1, OV);
    vecs[10] = mk(0, 0, 8'h00, 1,  1, 1, 8'h03, 3'd2, 0, OV);
    vecs[11] = mk(1, 1, 8'hEE, 1,  1, 0, 8'h00, 3'd0, 0, 0);   // flush beats push and pop
    vecs[12] = mk(0, 0, 8'h00, 0,  1, 0, 8'h00, 3'd0, 0, 0);
    vecs[13] = mk(0, 1, 8'h77, 0,  1, 1, 8'h77, 3'd1, 0, 0);
    vecs[14] = mk(0, 0, 8'h00, 1,  1, 0, 8'h00, 3'd0, 0, 0);

    repeat (3) tick();
    chk("rst_wr_ready", 32'(wr_ready_o), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid_o), 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_afull", 32'(almost_full_o), 32'd0);
    chk("rst_ovf", 32'(ovf_o), 32'd0);
    rst_i = 1'b0;
    chk("rel_wr_ready_before_edge", 32'(wr_ready_o), 32'd0);

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].flush, vecs[i].wv, vecs[i].wd, vecs[i].rr);
      tick();
      chk($sformatf("v%0d_wr_ready", i), 32'(wr_ready_o), 32'(vecs[i].e_wrdy));
      chk($sformatf("v%0d_rd_valid", i), 32'(rd_valid_o), 32'(vecs[i].e_rv));
      if (vecs[i].e_rv)
        chk($sformatf("v%0d_rdata", i), 32'(rd_rdata_o), 32'(vecs[i].e_rd));
      chk($sformatf("v%0d_count", i), 32'(count_o), 32'(vecs[i].e_cnt));
      chk($sformatf("v%0d_afull", i), 32'(almost_full_o), 32'(vecs[i].e_af));
      chk($sformatf("v%0d_ovf", i), 32'(ovf_o), 32'(vecs[i].e_ovf));
    end

    // Streaming: one word resident, push and pop every cycle across several pointer wraps.
    drive(0, 1, 8'h10, 0);
    tick();
    chk("stream_prime_count", 32'(count_o), 32'd1);
    for (int i = 1; i < 20; i++) begin
      drive(0, 1, 8'(8'h10 + i), 1);
      chk($sformatf("stream_head_%0d", i), 32'(rd_rdata_o), 32'(8'h10 + i - 1));
      tick();
      chk($sformatf("stream_count_%0d", i), 32'(count_o), 32'd1);
    end
    drive(0, 0, 8'h00, 1);
    chk("stream_last_head", 32'(rd_rdata_o), 32'h23);
    tick();
    chk("stream_drained", 32'(count_o), 32'd0);
    chk("stream_wr_ready", 32'(wr_ready_o), 32'd1);

    // Async reset mid-burst at count 3.
    drive(0, 1, 8'hB0, 0); tick();
    drive(0, 1, 8'hB1, 0); tick();
    drive(0, 1, 8'hB2, 0); tick();
    chk("burst_count", 32'(count_o), 32'd3);
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst_count", 32'(count_o), 32'd0);
    chk("arst_wr_ready", 32'(wr_ready_o), 32'd0);
    chk("arst_rd_valid", 32'(rd_valid_o), 32'd0);
    chk("arst_afull", 32'(almost_full_o), 32'd0);
    chk("arst_ovf", 32'(ovf_o), 32'd0);
    drive(0, 0, 8'h00, 0);
    tick();
    rst_i = 1'b0;
    chk("arst_rel_wr_ready_before", 32'(wr_ready_o), 32'd0);
    tick();
    chk("arst_rel_wr_ready_after", 32'(wr_ready_o), 32'd1);
    chk("arst_rel_count", 32'(count_o), 32'd0);
    chk("arst_rel_rd_valid", 32'(rd_valid_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_fifo_sync.md
Name: axi_fifo_sync

Overview:
- Single-clock, parametrised AXI-stream-style FIFO with valid/ready on both sides. Successor to the dual-clock AXI FIFO wrapper.
- Adds level count, programmable almost-full, synchronous flush, a registered write-ready, and optional overflow detection.
- Sits between testbench AXI masters/slaves and DLA bus models where both sides share one clock. Depth-independent handshake timing.

Parameters:
- WIDTH, 57, data width in bits (≥1).
- DEPTH, 8, number of entries; power of two, ≥2.
- AFULL_THRESH, DEPTH-2, level at or above which almost_full_o asserts (1..DEPTH).

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- flush_i  in  1  synchronous flush; empties the FIFO.
- wr_valid_i  in  1  write-side data valid.
- wr_wdata_i  in  WIDTH  write data.
- wr_ready_o  out  1  write side may accept (registered).
- rd_valid_o  out  1  head entry valid.
- rd_rdata_o  out  WIDTH  head entry data (first-word fall-through).
- rd_ready_i  in  1  read-side consumer ready.
- count_o  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- almost_full_o  out  1  count_o ≥ AFULL_THRESH.
- ovf_o  out  1  sticky overflow flag (optional feature).

Behaviour:
- Reset (rst_i high, async):
  - Write pointer, read pointer and count cleared to 0.
  - wr_ready_o=0, rd_valid_o=0, almost_full_o=0, ovf_o=0.
  - Storage contents are not reset. rd_rdata_o is undefined while rd_valid_o=0.
- First clock edge after rst_i deasserts: wr_ready_o goes to 1. No write is accepted on that edge.
- Push occurs when wr_valid_i && wr_ready_o at the clock edge. Data is written at the write pointer, which increments modulo DEPTH.
- Pop occurs when rd_valid_o && rd_ready_i at the clock edge. The read pointer increments modulo DEPTH.
- rd_valid_o = (count != 0). rd_rdata_o = storage[read pointer], combinational from flop storage.
- Latency:
  - Push into an empty FIFO gives rd_valid_o=1 one cycle later. There is no same-cycle bypass.
  - Pop-to-next-data latency is 0: the next head appears the cycle after the pop edge.
- Count update:
  - push only: +1.
  - pop only: −1.
  - both: unchanged.
  - neither: unchanged.
- wr_ready_o is registered and equals (next_count != DEPTH).
  - When full, a same-cycle pop does not enable a push in that cycle. wr_ready_o rises on the following cycle.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are decided from count, not pointer compare.
- almost_full_o is combinational from count_o.
- flush_i:
  - Has priority over push and pop in the same cycle. Pointers and count go to 0 and the incoming write is dropped.
  - wr_ready_o stays 1 after flush.
- No handshake deadlock: wr_ready_o does not depend on wr_valid_i, and rd_valid_o does not depend on rd_ready_i.
- Asserting rst_i mid-transfer discards all contents. Outputs follow the reset values immediately.

Optional Feature:
- Macro: AXI_FIFO_OVF_EN.
- Defined: ovf_o is set on any cycle with wr_valid_i=1 && wr_ready_o=0 while not in reset and flush_i=0.
  - It stays set until flush_i or rst_i.
  - For simulation, the block also prints a $display warning with the simulation time on the first set.
- Undefined: ovf_o is tied to 0 and no detection logic is present. The port list is identical in both builds.

Decomposition:
- Package axi_fifo_pkg:
  - function for count width.
  - localparam defaults (WIDTH=57, DEPTH=8).
  - elaboration check that DEPTH is a power of two and that AFULL_THRESH is in range.
- Sub-module axi_fifo_sync_mem: WIDTH×DEPTH flop array with one write port and one asynchronous read port.
- Top axi_fifo_sync holds the pointers, count, ready/valid logic, flush and overflow logic.

Test Plan (WIDTH=8, DEPTH=4, AFULL_THRESH=3 unless stated):
- Reset release, then push 0xA1 one cycle after wr_ready_o rises → rd_valid_o=1 and rd_rdata_o=0xA1 next cycle; count_o=1.
- Push 0x01..0x04 back-to-back with rd_ready_i=0 → almost_full_o=1 at count 3; wr_ready_o=0 after the 4th push. A 5th wr_valid_i is not accepted and sets ovf_o=1 only when AXI_FIFO_OVF_EN is defined.
- Full FIFO, pop and offer a push in the same cycle → pop of 0x01 accepted, push not accepted; count_o=3; wr_ready_o=1 next cycle.
- Continuous push and pop every cycle for 20 words 0x10..0x23 → count_o stays 1; output order identical to input across pointer wrap.
- Count 2 with flush_i=1, wr_valid_i=1, rd_ready_i=1 in the same cycle → count_o=0, rd_valid_o=0 and ovf_o=0 next cycle; the flushed write never appears at the output.
- Assert rst_i asynchronously mid-burst at count 3 → outputs reset immediately without a clock edge; count_o=0, wr_ready_o=0, then 1 one edge after release.
